// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store. Each granted access holds mem_en for MEM_LAT cycles and then pulses done.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              last_grant, last_grant_next;
    logic              elig_if, elig_d;
    logic              grant_if, grant_d;
    logic              finish;

    logic              mem_en_next, mem_wr_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next;
    logic [DATA_W-1:0] if_rdata_next, d_rdata_next;
    logic              if_done_next, d_done_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A port whose done is high this cycle is masked: its requester has not yet dropped req.
    always_comb begin
        elig_if    = if_req & ~if_done;
        elig_d     = d_req & ~d_done;
        grant_if   = elig_if & (~elig_d | last_grant);
        grant_d    = elig_d & ~grant_if;
        finish     = (state != IDLE) && (cnt == '0);
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_if) begin
                    state_next = BUSY_IF;
                end else if (grant_d) begin
                    state_next = BUSY_D;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next        = cnt;
        last_grant_next = last_grant;
        mem_en_next     = mem_en;
        mem_wr_next     = mem_wr;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        if_rdata_next   = if_rdata;
        d_rdata_next    = d_rdata;
        if_done_next    = 1'b0;
        d_done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_if) begin
                    cnt_next        = CNT_W'(MEM_LAT - 1);
                    last_grant_next = 1'b0;
                    mem_en_next     = 1'b1;
                    mem_wr_next     = 1'b0;
                    mem_addr_next   = if_addr;
                end else if (grant_d) begin
                    cnt_next        = CNT_W'(MEM_LAT - 1);
                    last_grant_next = 1'b1;
                    mem_en_next     = 1'b1;
                    mem_wr_next     = d_wr;
                    mem_addr_next   = d_addr;
                    mem_wdata_next  = d_wdata;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (!finish) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    mem_en_next = 1'b0;
                    mem_wr_next = 1'b0;
                    if (state == BUSY_IF) begin
                        if_done_next  = 1'b1;
                        if_rdata_next = mem_rdata;
                    end else begin
                        d_done_next = 1'b1;
                        if (!mem_wr) begin
                            d_rdata_next = mem_rdata;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            last_grant <= last_grant_next;
            mem_en     <= mem_en_next;
            mem_wr     <= mem_wr_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            if_rdata   <= if_rdata_next;
            d_rdata    <= d_rdata_next;
            if_done    <= if_done_next;
            d_done     <= d_done_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port `memory2c` instance between the CPU's instruction-fetch path and its load/store path, for the unified-memory build of the core. Each side raises a level request and holds it until a one-cycle done pulse. The arbiter grants round-robin, drives the memory port for a fixed `MEM_LAT` cycles, captures read data, and returns it on the owning port. Its `busy` and done outputs are what the PC and pipeline-stall logic key on.

## Interface
- `ADDR_W`, 32: address width of both requesters and the memory port.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 1: number of cycles `mem_en` is held per access; must be ≥ 1. Read data is sampled at the end of the last cycle.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-low.
- `if_req` in 1: fetch request, level.
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetched word, registered.
- `if_done` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: data request, level.
- `d_wr` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load result, registered.
- `d_done` out 1: one-cycle completion pulse for data.
- `mem_en` out 1: memory enable, registered.
- `mem_wr` out 1: memory write, registered.
- `mem_addr` out ADDR_W: memory address, registered.
- `mem_wdata` out DATA_W: memory write data, registered.
- `mem_rdata` in DATA_W: memory read data; combinational from the memory.
- `busy` out 1: high while an access is in flight (state ≠ IDLE).

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D.
- Internal state:
  - `cnt`, width $clog2(MEM_LAT)+1.
  - `last_grant`, 0 = fetch, 1 = data.
- Request masking in IDLE:
  - eligible_if = `if_req & ~if_done`.
  - eligible_d = `d_req & ~d_done`.
  - This masks the port that completed in that cycle, since its requester has not yet seen done.
- Grant in IDLE:
  - Only one port eligible: that port is granted.
  - Both eligible: the port ≠ `last_grant` is granted.
  - Granting updates `last_grant`.
  - Grant to fetch → BUSY_IF; grant to data → BUSY_D.
  - On grant: `cnt` ← MEM_LAT−1; `mem_en` ← 1; `mem_addr` ← granted address.
  - Fetch grant: `mem_wr` ← 0.
  - Data grant: `mem_wr` ← `d_wr` and `mem_wdata` ← `d_wdata`.
- BUSY states:
  - `mem_*` outputs held constant.
  - `cnt` ≠ 0: decrement.
  - `cnt` = 0: go to IDLE, drop `mem_en`/`mem_wr` to 0, and pulse the owning done for the next cycle.
  - Owner is a read: capture `mem_rdata` into `if_rdata` / `d_rdata`.
  - Owner is a store: `d_rdata` is unchanged.
- In IDLE, `mem_addr`/`mem_wdata` hold their last values; `mem_en` = `mem_wr` = 0.
- Requesters must hold `*_addr`, `d_wr` and `d_wdata` stable from `req` rise until their done pulse. The arbiter samples them only at grant.
- A store with MEM_LAT > 1 rewrites the same word on each enabled edge. This is required to be benign.

## Timing
- Reset (`rst`=0 sampled at an edge), outputs from the next cycle:
  - FSM → IDLE; `cnt`=0; `last_grant`=1, so fetch wins the first tie.
  - `mem_en`=`mem_wr`=0; `mem_addr`=`mem_wdata`=0.
  - `if_rdata`=`d_rdata`=0; `if_done`=`d_done`=0; `busy`=0.
- Reset mid-access: the in-flight access is abandoned with no done pulse. After reset releases, a request still held is re-arbitrated from scratch.
- Request sampled in IDLE at the end of cycle 0:
  - `mem_en` high in cycles 1..MEM_LAT.
  - Done high in cycle MEM_LAT+1; rdata valid from cycle MEM_LAT+1.
- Latency, request to done: MEM_LAT+1 cycles.
- Peak throughput: one access per MEM_LAT+1 cycles. The other port can be granted in a done cycle, so back-to-back alternating accesses have no bubble beyond that.
- `busy` is high in cycles 1..MEM_LAT of each access.
- At most one done pulse per cycle; `if_done` and `d_done` are never high together.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `if_req`=`d_req`=1 → all outputs 0 and no `mem_en`. On release, fetch is granted first (`mem_wr`=0, `mem_addr`=`if_addr`).
- Single fetch, MEM_LAT=2, `if_addr`=0x10, memory returns 0x00A00093 at 0x10 → `mem_en` high in cycles 1–2, `if_done` in cycle 3, `if_rdata`=0x00A00093, `busy` low in cycle 3.
- Both requests held continuously, MEM_LAT=1 → grants alternate IF, D, IF, D; done pulses every 2 cycles with alternating owner; no port is granted twice in a row.
- Store, `d_addr`=0x40, `d_wdata`=0xDEADBEEF, `d_wr`=1 → `mem_en`=`mem_wr`=1 with addr 0x40 for MEM_LAT cycles, then one `d_done` pulse with `d_rdata` unchanged. A following load at 0x40 returns 0xDEADBEEF.
- Reset mid-access: `rst`=0 in cycle 1 of a fetch with MEM_LAT=3 → `mem_en`=0 the next cycle and no `if_done`. After release with `if_req` still high, a fresh full-latency fetch completes.
- Data-only stream: `d_req` re-asserted immediately after each `d_done`, `if_req`=0 → every grant goes to data; accesses spaced MEM_LAT+1 cycles; the just-done port is masked in its done cycle.
